// File: rtl/asynchronous_fifo_controller_if.sv
// Producer, consumer and RAM-port signals of the asynchronous FIFO controller.
// ASYNCHRONOUS_FIFO_CONTROLLER_LEVEL_EN adds the write_level/read_level outputs.
interface asynchronous_fifo_controller_if #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
) ();
  logic                     write_enable;
  logic [WIDTH-1:0]         write_data;
  logic                     full;
  logic                     read_enable;
  logic [WIDTH-1:0]         read_data;
  logic                     empty;
  logic                     memory_write_enable;
  logic [ADDRESS_WIDTH-1:0] memory_write_address;
  logic [WIDTH-1:0]         memory_write_data;
  logic                     memory_read_enable;
  logic [ADDRESS_WIDTH-1:0] memory_read_address;
  logic [WIDTH-1:0]         memory_read_data;
`ifdef ASYNCHRONOUS_FIFO_CONTROLLER_LEVEL_EN
  logic [ADDRESS_WIDTH:0]   write_level;
  logic [ADDRESS_WIDTH:0]   read_level;
`endif

  // The controller side.
  modport slave (
    input  write_enable, write_data, read_enable, memory_read_data,
    output full, read_data, empty,
    output memory_write_enable, memory_write_address, memory_write_data,
    output memory_read_enable, memory_read_address
`ifdef ASYNCHRONOUS_FIFO_CONTROLLER_LEVEL_EN
    , output write_level, read_level
`endif
  );

  // Producer, consumer and RAM seen together.
  modport master (
    output write_enable, write_data, read_enable, memory_read_data,
    input  full, read_data, empty,
    input  memory_write_enable, memory_write_address, memory_write_data,
    input  memory_read_enable, memory_read_address
`ifdef ASYNCHRONOUS_FIFO_CONTROLLER_LEVEL_EN
    , input write_level, read_level
`endif
  );
endinterface

// File: rtl/asynchronous_fifo_controller.sv
// Gray-pointer CDC FIFO controller driving an external dual-port RAM.
// Define ASYNCHRONOUS_FIFO_CONTROLLER_LEVEL_EN to add registered write_level/read_level.
module asynchronous_fifo_controller #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int SYNC_STAGES   = 2
) (
  input  logic                          write_clock,
  input  logic                          write_resetn,
  input  logic                          read_clock,
  input  logic                          read_resetn,
  asynchronous_fifo_controller_if.slave bus
);

  typedef logic [ADDRESS_WIDTH:0] pointer_t;

  // Gray pattern of the read pointer exactly DEPTH entries behind the write pointer.
  localparam pointer_t FULL_MASK = pointer_t'(3) << (ADDRESS_WIDTH - 1);

  function automatic pointer_t bin2gray(input pointer_t binary);
    return binary ^ (binary >> 1);
  endfunction

  // ---------------- write domain ----------------
  pointer_t write_pointer_binary, write_pointer_gray;
  pointer_t write_pointer_binary_next, write_pointer_gray_next;
  pointer_t read_pointer_gray_synchronized;
  logic [SYNC_STAGES-1:0][ADDRESS_WIDTH:0] read_pointer_gray_chain;
  logic write_accept, full;

  // ---------------- read domain -----------------
  pointer_t read_pointer_binary, read_pointer_gray;
  pointer_t read_pointer_binary_next, read_pointer_gray_next;
  pointer_t write_pointer_gray_synchronized;
  logic [SYNC_STAGES-1:0][ADDRESS_WIDTH:0] write_pointer_gray_chain;
  logic read_accept, empty;

  assign write_accept                   = bus.write_enable && !full;
  assign write_pointer_binary_next      = write_pointer_binary + pointer_t'(write_accept);
  assign write_pointer_gray_next        = bin2gray(write_pointer_binary_next);
  assign read_pointer_gray_synchronized = read_pointer_gray_chain[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge write_clock or negedge write_resetn) begin
    if (!write_resetn) begin
      write_pointer_binary <= '0;
      write_pointer_gray   <= '0;
      full                 <= 1'b0;
    end else begin
      write_pointer_binary <= write_pointer_binary_next;
      write_pointer_gray   <= write_pointer_gray_next;
      full                 <= (write_pointer_gray_next == (read_pointer_gray_synchronized ^ FULL_MASK));
    end
  end

  // NOTE: synchronizer flops are reset too, so a fresh FIFO never sees a stale foreign pointer.
  always_ff @(posedge write_clock or negedge write_resetn) begin
    if (!write_resetn) read_pointer_gray_chain <= '0;
    else               read_pointer_gray_chain <= {read_pointer_gray_chain[SYNC_STAGES-2:0], read_pointer_gray};
  end

  assign read_accept                     = bus.read_enable && !empty;
  assign read_pointer_binary_next        = read_pointer_binary + pointer_t'(read_accept);
  assign read_pointer_gray_next          = bin2gray(read_pointer_binary_next);
  assign write_pointer_gray_synchronized = write_pointer_gray_chain[SYNC_STAGES-1];

  always_ff @(posedge read_clock or negedge read_resetn) begin
    if (!read_resetn) begin
      read_pointer_binary <= '0;
      read_pointer_gray   <= '0;
      empty               <= 1'b1;
    end else begin
      read_pointer_binary <= read_pointer_binary_next;
      read_pointer_gray   <= read_pointer_gray_next;
      empty               <= (read_pointer_gray_next == write_pointer_gray_synchronized);
    end
  end

  always_ff @(posedge read_clock or negedge read_resetn) begin
    if (!read_resetn) write_pointer_gray_chain <= '0;
    else              write_pointer_gray_chain <= {write_pointer_gray_chain[SYNC_STAGES-2:0], write_pointer_gray};
  end

  assign bus.full                 = full;
  assign bus.empty                = empty;
  assign bus.memory_write_enable  = write_accept;
  assign bus.memory_write_address = write_pointer_binary[ADDRESS_WIDTH-1:0];
  assign bus.memory_write_data    = bus.write_data;
  assign bus.memory_read_enable   = read_accept;
  assign bus.memory_read_address  = read_pointer_binary[ADDRESS_WIDTH-1:0];
  // The RAM registers its read port, so its output already has the one-cycle latency and hold.
  assign bus.read_data            = bus.memory_read_data;

`ifdef ASYNCHRONOUS_FIFO_CONTROLLER_LEVEL_EN
  function automatic pointer_t gray2bin(input pointer_t gray);
    pointer_t binary;
    binary[ADDRESS_WIDTH] = gray[ADDRESS_WIDTH];
    for (int i = ADDRESS_WIDTH - 1; i >= 0; i--) binary[i] = binary[i+1] ^ gray[i];
    return binary;
  endfunction

  pointer_t write_level, read_level;

  // Levels use the same post-edge pointer as the flags, so DEPTH coincides with full.
  always_ff @(posedge write_clock or negedge write_resetn) begin
    if (!write_resetn) write_level <= '0;
    else               write_level <= write_pointer_binary_next - gray2bin(read_pointer_gray_synchronized);
  end

  always_ff @(posedge read_clock or negedge read_resetn) begin
    if (!read_resetn) read_level <= '0;
    else              read_level <= gray2bin(write_pointer_gray_synchronized) - read_pointer_binary_next;
  end

  assign bus.write_level = write_level;
  assign bus.read_level  = read_level;
`endif

endmodule
